// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exec_sequencer
// Description : Instruction fetch / decode / execute / retire sequencer.
//               Fetches one word at a time, classifies the opcode, strobes
//               the selected execution unit for one cycle and retires it.
//               Unknown opcodes park the block in TRAP until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_sequencer (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] program_counter,
    output logic        en_lui_n,
    output logic        en_auipc_n,
    output logic        en_opimm_n,
    output logic        en_op_n,
    output logic        reg_we,
    output logic        retired,
    output logic [31:0] instret,
    output logic        illegal
);

    localparam logic [2:0] c_ST_FETCH   = 3'd0;
    localparam logic [2:0] c_ST_DECODE  = 3'd1;
    localparam logic [2:0] c_ST_EXECUTE = 3'd2;
    localparam logic [2:0] c_ST_RETIRE  = 3'd3;
    localparam logic [2:0] c_ST_TRAP    = 3'd4;

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    // One-hot unit selects; bit order matches the enable vector below.
    localparam logic [3:0] c_SEL_LUI    = 4'b0001;
    localparam logic [3:0] c_SEL_AUIPC  = 4'b0010;
    localparam logic [3:0] c_SEL_OPIMM  = 4'b0100;
    localparam logic [3:0] c_SEL_OP     = 4'b1000;

    localparam logic [31:0] c_PC_STEP   = 32'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_instret;
    logic        r_illegal;
    logic [3:0]  r_unit_sel;
    logic [3:0]  w_dec_sel;
    logic [3:0]  w_en_n;
    logic        w_req;
    logic        w_we;
    logic        w_retired;

    // Opcode classifier; an all-zero result marks an illegal instruction
    // (this also covers any word whose low two bits are not 2'b11).
    always_comb begin
        w_dec_sel = 4'b0000;
        case (r_ir[6:0])
            c_OPC_LUI:   w_dec_sel = c_SEL_LUI;
            c_OPC_AUIPC: w_dec_sel = c_SEL_AUIPC;
            c_OPC_OPIMM: w_dec_sel = c_SEL_OPIMM;
            c_OPC_OP:    w_dec_sel = c_SEL_OP;
            default:     w_dec_sel = 4'b0000;
        endcase
    end

    // Next-state and strobe generation; outputs depend on state only, so
    // imem_ack never reaches imem_req combinationally.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_en_n      = 4'b1111;
        w_we        = 1'b0;
        w_retired   = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                w_req = 1'b1;
                if (imem_ack) begin
                    w_state_nxt = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                w_state_nxt = (w_dec_sel != 4'b0000) ? c_ST_EXECUTE : c_ST_TRAP;
            end
            c_ST_EXECUTE: begin
                w_en_n      = ~r_unit_sel;
                w_we        = (r_ir[11:7] != 5'd0);
                w_state_nxt = c_ST_RETIRE;
            end
            c_ST_RETIRE: begin
                w_retired   = 1'b1;
                w_state_nxt = c_ST_FETCH;
            end
            c_ST_TRAP: begin
                w_state_nxt = c_ST_TRAP;
            end
            default: begin
                w_state_nxt = c_ST_FETCH;
            end
        endcase
    end

    // State register; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Architectural registers: IR capture, unit select, PC/instret, trap flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= 32'd0;
            r_ir       <= 32'd0;
            r_instret  <= 32'd0;
            r_illegal  <= 1'b0;
            r_unit_sel <= 4'b0000;
        end else begin
            if ((r_state == c_ST_FETCH) && imem_ack) begin
                r_ir <= imem_rdata;
            end
            if (r_state == c_ST_DECODE) begin
                r_unit_sel <= w_dec_sel;
                if (w_dec_sel == 4'b0000) begin
                    r_illegal <= 1'b1;
                end
            end
            if (r_state == c_ST_RETIRE) begin
                r_pc      <= r_pc + c_PC_STEP;
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign imem_req        = w_req;
    assign imem_addr       = r_pc;
    assign program_counter = r_pc;
    assign instruction     = r_ir;
    assign en_lui_n        = w_en_n[0];
    assign en_auipc_n      = w_en_n[1];
    assign en_opimm_n      = w_en_n[2];
    assign en_op_n         = w_en_n[3];
    assign reg_we          = w_we;
    assign retired         = w_retired;
    assign instret         = r_instret;
    assign illegal         = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_sequencer
// Description : Directed, table-driven bench for exec_sequencer plus short
//               hand-written sequences for PC/instret wrap and throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] program_counter;
    logic        en_lui_n;
    logic        en_auipc_n;
    logic        en_opimm_n;
    logic        en_op_n;
    logic        reg_we;
    logic        retired;
    logic [31:0] instret;
    logic        illegal;

    int n_cmp;
    int n_err;

    exec_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instruction     (instruction),
        .program_counter (program_counter),
        .en_lui_n        (en_lui_n),
        .en_auipc_n      (en_auipc_n),
        .en_opimm_n      (en_opimm_n),
        .en_op_n         (en_op_n),
        .reg_we          (reg_we),
        .retired         (retired),
        .instret         (instret),
        .illegal         (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic [31:0] ir;
        logic [3:0]  en;   // {op, opimm, auipc, lui}, active low
        logic        we;
        logic        ret;
        logic [31:0] icnt;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic ack, logic [31:0] rdata,
                                logic req, logic [31:0] addr, logic [31:0] ir,
                                logic [3:0] en, logic we, logic ret,
                                logic [31:0] icnt, logic ill);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdata = rdata;
        v.req = req; v.addr = addr; v.ir = ir; v.en = en;
        v.we = we; v.ret = ret; v.icnt = icnt; v.ill = ill;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [step %0d]: got 0x%08h, want 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] en_vec();
        return {en_op_n, en_opimm_n, en_auipc_n, en_lui_n};
    endfunction

    localparam logic [31:0] c_LUI   = 32'h0000_1537;
    localparam logic [31:0] c_AUIPC = 32'h0000_0517;
    localparam logic [31:0] c_OPIMM = 32'h0010_0013;
    localparam logic [31:0] c_OP    = 32'h0020_81B3;

    int t_ret[3];
    int n_ret;
    int cyc;

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'd0;

        //            rst ack rdata          req addr          ir             en       we ret icnt ill
        // LUI x10, ack on first FETCH cycle
        vecs.push_back(mk(1, 0, 32'h0,          1, 32'h0, 32'h0,         4'b1111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, c_LUI,          0, 32'h0, c_LUI,         4'b1111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0, c_LUI,         4'b1110, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0, c_LUI,         4'b1111, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 32'h4, c_LUI,         4'b1111, 0, 0, 1, 0));
        // AUIPC after reset with three wait cycles; stray ack outside FETCH ignored
        vecs.push_back(mk(1, 0, 32'h0,          1, 32'h0, 32'h0,         4'b1111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 32'h0, 32'h0,         4'b1111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 32'h0, 32'h0,         4'b1111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 32'h0, 32'h0,         4'b1111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, c_AUIPC,        0, 32'h0, c_AUIPC,       4'b1111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hDEADBEEF,   0, 32'h0, c_AUIPC,       4'b1101, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hDEADBEEF,   0, 32'h0, c_AUIPC,       4'b1111, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 32'h4, c_AUIPC,       4'b1111, 0, 0, 1, 0));
        // OP-IMM writing x0: unit enabled, no write strobe, still retires
        vecs.push_back(mk(0, 1, c_OPIMM,        0, 32'h4, c_OPIMM,       4'b1111, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h4, c_OPIMM,       4'b1011, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h4, c_OPIMM,       4'b1111, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 32'h8, c_OPIMM,       4'b1111, 0, 0, 2, 0));
        // Illegal 0x7F -> TRAP, frozen, then reset clears
        vecs.push_back(mk(0, 1, 32'h7F,         0, 32'h8, 32'h7F,        4'b1111, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h8, 32'h7F,        4'b1111, 0, 0, 2, 1));
        vecs.push_back(mk(0, 1, c_LUI,          0, 32'h8, 32'h7F,        4'b1111, 0, 0, 2, 1));
        vecs.push_back(mk(1, 0, 32'h0,          1, 32'h0, 32'h0,         4'b1111, 0, 0, 0, 0));
        // 0xFFFFFFFF -> TRAP; reset with simultaneous ack wins
        vecs.push_back(mk(0, 1, 32'hFFFFFFFF,   0, 32'h0, 32'hFFFFFFFF,  4'b1111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0, 32'hFFFFFFFF,  4'b1111, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, c_LUI,          1, 32'h0, 32'h0,         4'b1111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 32'h0, 32'h0,         4'b1111, 0, 0, 0, 0));
        // OP retires once, then reset lands in the EXECUTE of a second OP
        vecs.push_back(mk(0, 1, c_OP,           0, 32'h0, c_OP,          4'b1111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0, c_OP,          4'b0111, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0, c_OP,          4'b1111, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 32'h4, c_OP,          4'b1111, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, c_OP,           0, 32'h4, c_OP,          4'b1111, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h4, c_OP,          4'b0111, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,          1, 32'h0, 32'h0,         4'b1111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 32'h0, 32'h0,         4'b1111, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            reset      = vecs[i].rst;
            imem_ack   = vecs[i].ack;
            imem_rdata = vecs[i].rdata;
            tick();
            check("imem_req",    i, {31'd0, imem_req},  {31'd0, vecs[i].req});
            check("imem_addr",   i, imem_addr,          vecs[i].addr);
            check("pc",          i, program_counter,    vecs[i].addr);
            check("instruction", i, instruction,        vecs[i].ir);
            check("en_n",        i, {28'd0, en_vec()},  {28'd0, vecs[i].en});
            check("reg_we",      i, {31'd0, reg_we},    {31'd0, vecs[i].we});
            check("retired",     i, {31'd0, retired},   {31'd0, vecs[i].ret});
            check("instret",     i, instret,            vecs[i].icnt);
            check("illegal",     i, {31'd0, illegal},   {31'd0, vecs[i].ill});
        end

        // PC and instret wrap via backdoor load while parked in FETCH.
        reset = 1'b0;
        imem_ack = 1'b0;
        dut.r_pc      = 32'hFFFF_FFFC;
        dut.r_instret = 32'hFFFF_FFFF;
        #1;
        check("wrap_addr_pre", 100, imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1;
        imem_rdata = c_OP;
        tick();
        imem_ack = 1'b0;
        tick();
        check("wrap_en_n", 101, {28'd0, en_vec()}, 32'h7);
        tick();
        check("wrap_retired", 102, {31'd0, retired}, 32'd1);
        tick();
        check("wrap_pc",      103, program_counter, 32'h0);
        check("wrap_instret", 103, instret,         32'h0);
        check("wrap_illegal", 103, {31'd0, illegal}, 32'd0);
        check("wrap_req",     103, {31'd0, imem_req}, 32'd1);

        // Throughput: ack held high, retire spacing must be 4 cycles.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = c_LUI;
        n_ret = 0;
        cyc = 0;
        while (n_ret < 3 && cyc < 40) begin
            tick();
            cyc++;
            check("one_hot_en", 200 + cyc, {31'd0, ($countones(~en_vec()) <= 1)}, 32'd1);
            if (retired) begin
                t_ret[n_ret] = cyc;
                n_ret++;
            end
        end
        imem_ack = 1'b0;
        check("tput_count",  300, n_ret, 3);
        if (n_ret == 3) begin
            check("tput_first", 301, t_ret[0], 3);
            check("tput_gap1",  302, t_ret[1] - t_ret[0], 4);
            check("tput_gap2",  303, t_ret[2] - t_ret[1], 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-high reset; sampled on clk rising edge.
REQ-004 imem_req  output  1  instruction fetch request.
REQ-005 imem_addr  output  32  fetch address; equals program_counter.
REQ-006 imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instruction  output  32  latched instruction register (IR); fans out to all execution units.
REQ-009 program_counter  output  32  current PC; fans out to execution units.
REQ-010 en_lui_n, en_auipc_n, en_opimm_n, en_op_n  output  1 each  active-low unit enables; unit drives shared ALU/writeback buses only when its enable is low.
REQ-011 reg_we  output  1  register-file write strobe for the bus output_register/output_register_data.
REQ-012 retired  output  1  one-cycle pulse per completed instruction.
REQ-013 instret  output  32  retired-instruction counter.
REQ-014 illegal  output  1  sticky illegal-instruction flag.

Function
REQ-015 States SHALL be FETCH, DECODE, EXECUTE, RETIRE, TRAP; state encoding is free.
REQ-016 FETCH: imem_req=1, imem_addr=PC; the block SHALL hold FETCH until imem_ack=1, then latch IR<=imem_rdata and go to DECODE.
REQ-017 imem_ack and imem_rdata SHALL be ignored in every state other than FETCH.
REQ-018 DECODE (1 cycle): classify IR[6:0]: 0110111 LUI, 0010111 AUIPC, 0010011 OP-IMM, 0110011 OP; store selection in a unit-select register; next EXECUTE.
REQ-019 DECODE: any other opcode, including IR[1:0]!=2'b11, SHALL go to TRAP.
REQ-020 EXECUTE (1 cycle): exactly one en_*_n SHALL be low, namely the selected unit; all others high.
REQ-021 EXECUTE: reg_we=1 iff IR[11:7]!=0; a write to x0 SHALL produce no reg_we pulse but still retire.
REQ-022 RETIRE (1 cycle): all enables high, reg_we=0, retired=1, PC<=PC+4 modulo 2^32, instret<=instret+1 modulo 2^32; next FETCH.
REQ-023 At most one en_*_n SHALL be low in any cycle; outside EXECUTE all en_*_n SHALL be high.
REQ-024 TRAP: imem_req=0, all enables high, reg_we=0, retired=0, illegal=1; PC, IR and instret frozen; only reset exits.
REQ-025 Throughput: with imem_ack in the first FETCH cycle, one instruction SHALL retire every 4 cycles; each FETCH wait cycle adds exactly one cycle.
REQ-026 PC wrap: PC=0xFFFFFFFC retiring SHALL yield PC=0x00000000 with no flag.
REQ-027 imem_req SHALL be a registered-state function only (no combinational path from imem_ack to imem_req).

Reset
REQ-028 While reset=1 at a rising edge: state<=FETCH, PC<=0, IR<=0, instret<=0, illegal<=0, unit-select cleared.
REQ-029 Outputs during and after the reset cycle: imem_req=1 (in FETCH), imem_addr=0, all en_*_n=1, reg_we=0, retired=0, illegal=0, instruction=0.
REQ-030 Reset SHALL take priority over all events, including imem_ack in the same cycle and reset asserted mid-EXECUTE or in TRAP; no reg_we or retired pulse SHALL follow a reset edge.

Verification
REQ-031 Reset, then ack on first FETCH cycle with 0x00001537 (LUI x10) -> DECODE, EXECUTE with en_lui_n=0 and reg_we=1, RETIRE retired=1, PC=4, instret=1, cycle 5 back in FETCH.
REQ-032 AUIPC 0x00000517 with imem_ack delayed 3 cycles -> imem_req held 4 cycles at imem_addr=0, en_auipc_n=0 for exactly one cycle, retire 3 cycles later.
REQ-033 OP-IMM to x0 (0x00100013) -> en_opimm_n=0 one cycle, reg_we stays 0, retired=1, instret increments.
REQ-034 Fetch 0x0000007F, then 0xFFFFFFFF after reset -> TRAP, illegal=1, imem_req=0, PC frozen, no enable low; reset clears illegal=0 and PC=0.
REQ-035 Force PC=0xFFFFFFFC via a stream of 2^30-1 retirements or a backdoor load, retire one OP -> PC=0; force instret=0xFFFFFFFF, retire -> instret=0.
REQ-036 Assert reset in EXECUTE cycle of OP -> next cycle en_op_n=1, reg_we=0, retired=0, PC=0, instret=0, state FETCH.
